// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline-control definitions used by the stall controller, decode and forwarding logic.
package hazard_stall_controller_pkg;

    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_INT_DRAIN  = 2'd1,
        ST_INT_PUSH   = 2'd2,
        ST_INT_VECTOR = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_stall_controller_load_use_detect.sv
// Flags a load in D/E whose destination is read by the instruction in F/D.
module load_use_detect
    import hazard_stall_controller_pkg::*;
(
    input  logic                  de_mem_read,
    input  logic [REG_ADDR_W-1:0] de_rdst,
    input  logic [REG_ADDR_W-1:0] fd_rsrc,
    input  logic [REG_ADDR_W-1:0] fd_rtgt,
    input  logic                  fd_use_src,
    input  logic                  fd_use_tgt,
    output logic                  load_use
);

    always_comb begin
        load_use = de_mem_read &
                   ((fd_use_src & (fd_rsrc == de_rdst)) |
                    (fd_use_tgt & (fd_rtgt == de_rdst)));
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// PC / F/D / D/E enable and flush sequencing: load-use stalls, branch flushes,
// memory freezes, interrupt entry, plus a saturating stall-cycle counter.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int PUSH_CYCLES  = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  de_mem_read,
    input  logic [REG_ADDR_W-1:0] de_rdst,
    input  logic [REG_ADDR_W-1:0] fd_rsrc,
    input  logic [REG_ADDR_W-1:0] fd_rtgt,
    input  logic                  fd_use_src,
    input  logic                  fd_use_tgt,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    input  logic                  int_req,
    output logic                  pc_en,
    output logic                  fd_en,
    output logic                  fd_flush,
    output logic                  de_en,
    output logic                  de_flush,
    output logic                  int_push,
    output logic                  pc_sel_vec,
    output logic                  int_ack,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int MAX_C = (DRAIN_CYCLES > PUSH_CYCLES) ? DRAIN_CYCLES : PUSH_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    state_t        state, state_nxt, dec_state;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_use;

    load_use_detect u_load_use_detect (
        .de_mem_read (de_mem_read),
        .de_rdst     (de_rdst),
        .fd_rsrc     (fd_rsrc),
        .fd_rtgt     (fd_rtgt),
        .fd_use_src  (fd_use_src),
        .fd_use_tgt  (fd_use_tgt),
        .load_use    (load_use)
    );

    // While reset is asserted the outputs decode as if in RUN.
    assign dec_state = reset ? state : ST_RUN;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pc_en      = 1'b1;
        fd_en      = 1'b1;
        de_en      = 1'b1;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;
        int_push   = 1'b0;
        pc_sel_vec = 1'b0;
        int_ack    = 1'b0;

        if (mem_busy) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            de_en = 1'b0;
        end else begin
            unique case (dec_state)
                ST_RUN: begin
                    if (load_use) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_flush = 1'b1;
                    end
                    if (int_req && !branch_taken) begin
                        state_nxt = ST_INT_DRAIN;
                        cnt_nxt   = CW'(DRAIN_CYCLES - 1);
                    end
                end
                ST_INT_DRAIN: begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    de_flush = 1'b1;
                    if (cnt == '0) begin
                        state_nxt = ST_INT_PUSH;
                        cnt_nxt   = CW'(PUSH_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_INT_PUSH: begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    de_flush = 1'b1;
                    int_push = 1'b1;
                    if (cnt == '0) begin
                        state_nxt = ST_INT_VECTOR;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_INT_VECTOR: begin
                    pc_sel_vec = 1'b1;
                    pc_en      = 1'b1;
                    fd_flush   = 1'b1;
                    int_ack    = 1'b1;
                    state_nxt  = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase

            // A taken branch overrides the enables but lets the sequence advance.
            if (branch_taken) begin
                pc_en    = 1'b1;
                fd_en    = 1'b1;
                de_en    = 1'b1;
                fd_flush = 1'b1;
                de_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed and randomized checks of hazard_stall_controller against a queue-based reference model.
module tb_hazard_stall_controller;

    localparam int DRAIN = 3;
    localparam int PUSH  = 2;
    localparam int K_DRAIN = 1;
    localparam int K_PUSH  = 2;
    localparam int K_VEC   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, de_mem_read, fd_use_src, fd_use_tgt, branch_taken, mem_busy, int_req;
    logic [2:0] de_rdst, fd_rsrc, fd_rtgt;
    logic       pc_en, fd_en, fd_flush, de_en, de_flush, int_push, pc_sel_vec, int_ack;
    logic [15:0] stall_cnt;

    logic       sm_reset, sm_mem_busy;
    logic       sm_pc_en, sm_fd_en, sm_fd_flush, sm_de_en, sm_de_flush, sm_int_push, sm_pc_sel_vec, sm_int_ack;
    logic [3:0] sm_cnt;

    hazard_stall_controller #(.DRAIN_CYCLES(DRAIN), .PUSH_CYCLES(PUSH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .de_mem_read(de_mem_read), .de_rdst(de_rdst),
        .fd_rsrc(fd_rsrc), .fd_rtgt(fd_rtgt), .fd_use_src(fd_use_src), .fd_use_tgt(fd_use_tgt),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .int_req(int_req),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_en(de_en), .de_flush(de_flush),
        .int_push(int_push), .pc_sel_vec(pc_sel_vec), .int_ack(int_ack), .stall_cnt(stall_cnt)
    );

    hazard_stall_controller #(.DRAIN_CYCLES(DRAIN), .PUSH_CYCLES(PUSH), .CNT_W(4)) u_sat (
        .clk(clk), .reset(sm_reset), .de_mem_read(1'b0), .de_rdst(3'd0),
        .fd_rsrc(3'd0), .fd_rtgt(3'd0), .fd_use_src(1'b0), .fd_use_tgt(1'b0),
        .branch_taken(1'b0), .mem_busy(sm_mem_busy), .int_req(1'b0),
        .pc_en(sm_pc_en), .fd_en(sm_fd_en), .fd_flush(sm_fd_flush), .de_en(sm_de_en),
        .de_flush(sm_de_flush), .int_push(sm_int_push), .pc_sel_vec(sm_pc_sel_vec),
        .int_ack(sm_int_ack), .stall_cnt(sm_cnt)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    // Pending interrupt-entry cycles, one entry per cycle; empty means normal running.
    int          seq_q[$];
    logic [15:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs applied; checks, advances the model, waits one cycle.
    task automatic cycle();
        logic lu;
        int   kind;
        logic e_pc, e_fd, e_de, e_fdf, e_def, e_push, e_vec, e_ack;
        #1;
        lu = de_mem_read && ((fd_use_src && fd_rsrc == de_rdst) || (fd_use_tgt && fd_rtgt == de_rdst));
        kind = (reset && seq_q.size() != 0) ? seq_q[0] : 0;
        {e_pc, e_fd, e_de, e_fdf, e_def, e_push, e_vec, e_ack} = 8'b1110_0000;
        if (mem_busy) begin
            {e_pc, e_fd, e_de} = 3'b000;
        end else begin
            if (kind == 0 && lu)      begin e_pc = 0; e_fd = 0; e_def = 1; end
            if (kind == K_DRAIN)      begin e_pc = 0; e_fd = 0; e_def = 1; end
            if (kind == K_PUSH)       begin e_pc = 0; e_fd = 0; e_def = 1; e_push = 1; end
            if (kind == K_VEC)        begin e_vec = 1; e_fdf = 1; e_ack = 1; end
            if (branch_taken)         begin e_pc = 1; e_fd = 1; e_de = 1; e_fdf = 1; e_def = 1; end
        end
        chk("pc_en", 32'(pc_en), 32'(e_pc));
        chk("fd_en", 32'(fd_en), 32'(e_fd));
        chk("de_en", 32'(de_en), 32'(e_de));
        chk("fd_flush", 32'(fd_flush), 32'(e_fdf));
        chk("de_flush", 32'(de_flush), 32'(e_def));
        chk("int_push", 32'(int_push), 32'(e_push));
        chk("pc_sel_vec", 32'(pc_sel_vec), 32'(e_vec));
        chk("int_ack", 32'(int_ack), 32'(e_ack));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (!reset) begin
            seq_q.delete();
            m_cnt = '0;
        end else begin
            if (!e_pc && m_cnt != 16'hFFFF) m_cnt++;
            if (!mem_busy) begin
                if (seq_q.size() != 0) void'(seq_q.pop_front());
                else if (int_req && !branch_taken) begin
                    repeat (DRAIN) seq_q.push_back(K_DRAIN);
                    repeat (PUSH)  seq_q.push_back(K_PUSH);
                    seq_q.push_back(K_VEC);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 0; de_mem_read = 0; fd_use_src = 0; fd_use_tgt = 0;
        branch_taken = 0; mem_busy = 0; int_req = 0;
        de_rdst = 0; fd_rsrc = 0; fd_rtgt = 0;
        sm_reset = 0; sm_mem_busy = 0;
        @(negedge clk);
        cycle(); cycle();
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        reset = 1;

        // Load-use stall for one cycle
        de_mem_read = 1; de_rdst = 3; fd_rsrc = 3; fd_use_src = 1;
        cycle();
        chk("t1_stall_cnt", 32'(stall_cnt), 32'd1);
        de_mem_read = 0;
        cycle();

        // Matching registers but no operand use: no stall
        de_mem_read = 1; fd_use_src = 0; fd_use_tgt = 0; fd_rtgt = 3;
        cycle();

        // Branch overrides a load-use hazard
        fd_use_src = 1; branch_taken = 1;
        cycle();
        branch_taken = 0; de_mem_read = 0;

        // Full interrupt entry
        int_req = 1;
        cycle();
        int_req = 0;
        repeat (6) cycle();
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd6);

        // Memory freeze during the first push cycle
        int_req = 1;
        cycle();
        int_req = 0;
        repeat (3) cycle();
        mem_busy = 1;
        repeat (4) cycle();
        mem_busy = 0;
        repeat (3) cycle();
        chk("t5_stall_cnt", 32'(stall_cnt), 32'd15);

        // Reset mid-drain aborts the sequence without acknowledge
        int_req = 1;
        cycle();
        int_req = 0;
        cycle();
        reset = 0;
        cycle();
        reset = 1;
        chk("t6_stall_cnt", 32'(stall_cnt), 32'd0);
        repeat (5) cycle();

        // Saturation on a narrow counter
        sm_reset = 1; sm_mem_busy = 1;
        repeat (14) cycle();
        chk("sat_14", 32'(sm_cnt), 32'd14);
        repeat (6) cycle();
        chk("sat_max", 32'(sm_cnt), 32'hF);
        sm_reset = 0;
        cycle();
        chk("sat_reset", 32'(sm_cnt), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            reset        = ($urandom_range(0, 49) != 0);
            int_req      = ($urandom_range(0, 19) == 0);
            de_mem_read  = int_req ? 1'b0 : 1'($urandom);
            de_rdst      = 3'($urandom);
            fd_rsrc      = 3'($urandom_range(0, 3));
            fd_rtgt      = 3'($urandom_range(0, 3));
            fd_use_src   = 1'($urandom);
            fd_use_tgt   = 1'($urandom);
            branch_taken = ($urandom_range(0, 9) == 0);
            mem_busy     = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
